fetch_decode: RTL and testbench

Fetch/decode controller upstream of the regfile/ALU datapath. Reads 16-bit instructions from a synchronous program memory, sequences them through a three-state fetch/decode/execute loop, and drives the datapath control bundle from the decoded instruction. Control bundle: `rs`, `rd`, `opcode`, `re`, `ri`, `fe`, `imm`. This replaces the hard-coded test sequencer with program-driven control.

---
 rtl/fetch_decode.sv | 186 ++++++++++++++++++
 tb/tb_fetch_decode.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// fetch_decode: program-driven control sequencer for the regfile/ALU datapath.
// Fetches 16-bit instructions from a synchronous-read program memory and runs
// them through a FETCH -> DECODE -> EXEC loop, one instruction per three cycles.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   run        start/continue; sampled in IDLE and when leaving EXEC
//   mem_addr   program-memory address (always the PC)
//   mem_rdata  instruction word, valid one cycle after mem_addr
//   rs, rd     ALU operand register selects
//   opcode     ALU operation code
//   re         one-hot register write enable (EXEC only)
//   ri         ALU second operand is imm
//   fe         flag-register write enable
//   imm        extended immediate
//   halted     HALT executed; sticky until reset
module fetch_decode #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           mem_rdata,
  output logic [3:0]            rs,
  output logic [3:0]            rd,
  output logic [4:0]            opcode,
  output logic [15:0]           re,
  output logic                  ri,
  output logic                  fe,
  output logic [15:0]           imm,
  output logic                  halted
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StHalt   = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] StartPc = ADDR_WIDTH'(START_ADDR);

  localparam logic [4:0] AluAnd = 5'b00001;
  localparam logic [4:0] AluOr  = 5'b00010;
  localparam logic [4:0] AluXor = 5'b00011;
  localparam logic [4:0] AluNot = 5'b00100;
  localparam logic [4:0] AluAdd = 5'b00101;
  localparam logic [4:0] AluSub = 5'b01001;
  localparam logic [4:0] AluLsh = 5'b01100;
  localparam logic [4:0] AluRsh = 5'b10011;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q, ir_d;
  logic                  halted_q, halted_d;

  logic [3:0] ir_op, ir_rdest, ir_ext, ir_rsrc;
  logic [7:0] ir_imm8;
  logic       is_halt;

  assign ir_op    = ir_q[15:12];
  assign ir_rdest = ir_q[11:8];
  assign ir_ext   = ir_q[7:4];
  assign ir_rsrc  = ir_q[3:0];
  assign ir_imm8  = ir_q[7:0];
  assign is_halt  = (ir_op == 4'hF);

  // Sequencer
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        // Memory was addressed during FETCH, so its data is valid now.
        ir_d    = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        if (is_halt) begin
          state_d  = StHalt;
          halted_d = 1'b1;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = run ? StFetch : StIdle;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= StartPc;
      ir_q     <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Register-form operation, selected by ext
  logic [4:0] reg_code;
  logic       reg_ok;
  always_comb begin
    reg_code = 5'b00000;
    reg_ok   = 1'b1;
    case (ir_ext)
      4'b0101: reg_code = AluAdd;
      4'b1001: reg_code = AluSub;
      4'b0001: reg_code = AluAnd;
      4'b0010: reg_code = AluOr;
      4'b0011: reg_code = AluXor;
      4'b0100: reg_code = AluNot;
      4'b1100: reg_code = AluLsh;
      4'b1101: reg_code = AluRsh;
      default: reg_ok   = 1'b0;
    endcase
  end

  // Immediate-form operation, selected by op
  logic [4:0] imm_code;
  logic       imm_ok;
  always_comb begin
    imm_code = 5'b00000;
    imm_ok   = 1'b1;
    case (ir_op)
      4'b0101: imm_code = AluAdd;
      4'b1001: imm_code = AluSub;
      4'b0001: imm_code = AluAnd;
      4'b0010: imm_code = AluOr;
      4'b0011: imm_code = AluXor;
      default: imm_ok   = 1'b0;
    endcase
  end

  // Control bundle: only live in EXEC, so an async reset kills re/fe at once.
  always_comb begin
    rs     = 4'h0;
    rd     = 4'h0;
    opcode = 5'b00000;
    re     = 16'h0000;
    ri     = 1'b0;
    fe     = 1'b0;
    imm    = 16'h0000;
    if (state_q == StExec) begin
      if (ir_op == 4'h0 && reg_ok) begin
        rd     = ir_rdest;
        rs     = (reg_code == AluNot) ? 4'h0 : ir_rsrc;
        opcode = reg_code;
        re     = 16'h0001 << ir_rdest;
        fe     = (reg_code == AluAdd) || (reg_code == AluSub);
      end else if (imm_ok) begin
        rd     = ir_rdest;
        ri     = 1'b1;
        opcode = imm_code;
        re     = 16'h0001 << ir_rdest;
        fe     = (imm_code == AluAdd) || (imm_code == AluSub);
        // Arithmetic immediates are signed, logic immediates are masks.
        imm    = fe ? {{8{ir_imm8[7]}}, ir_imm8} : {8'h00, ir_imm8};
      end
    end
  end

  assign mem_addr = pc_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Self-checking bench for fetch_decode: directed scenarios followed by a
// randomized program checked against an instruction-level reference model.
module tb_fetch_decode;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, run, run2;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata, re, imm;
  logic [3:0]  rs, rd;
  logic [4:0]  opcode;
  logic        ri, fe, halted;

  logic [1:0]  mem_addr2;
  logic [15:0] mem_rdata2, re2, imm2;
  logic [3:0]  rs2, rd2;
  logic [4:0]  opcode2;
  logic        ri2, fe2, halted2;

  logic [15:0] mem  [256];
  logic [15:0] mem2 [4];

  fetch_decode #(.ADDR_WIDTH(8), .START_ADDR(0)) u_dut (
    .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rs(rs), .rd(rd), .opcode(opcode), .re(re), .ri(ri), .fe(fe), .imm(imm),
    .halted(halted)
  );

  fetch_decode #(.ADDR_WIDTH(2), .START_ADDR(0)) u_dut_w2 (
    .clk(clk), .rst(rst), .run(run2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .rs(rs2), .rd(rd2), .opcode(opcode2), .re(re2), .ri(ri2), .fe(fe2), .imm(imm2),
    .halted(halted2)
  );

  // Synchronous-read program memories
  always @(posedge clk) mem_rdata  <= mem[mem_addr];
  always @(posedge clk) mem_rdata2 <= mem2[mem_addr2];

  int checks = 0;
  int errors = 0;
  int re_pulses = 0;
  int r1_writes = 0;
  int exp_pc = 0;

  // Regfile-side view: a write happens on any edge where re is active.
  always @(posedge clk) begin
    if (re != 16'h0000) re_pulses <= re_pulses + 1;
    if (re[1]) r1_writes <= r1_writes + 1;
  end

  // ALU code per operation number (ext for register form, op for immediate form).
  localparam int AluCode [16] = '{-1, 1, 2, 3, 4, 5, -1, -1, -1, 9, -1, -1, 12, 19, -1, -1};

  typedef struct packed {
    logic        valid;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [4:0]  opcode;
    logic [15:0] re;
    logic        ri;
    logic        fe;
    logic [15:0] imm;
  } ctl_t;

  function automatic ctl_t model(input logic [15:0] w);
    ctl_t m;
    int op, code, imm8;
    m    = '0;
    op   = int'(w[15:12]);
    code = -1;
    if (op == 0) code = AluCode[int'(w[7:4])];
    else if (op == 1 || op == 2 || op == 3 || op == 5 || op == 9) code = AluCode[op];
    if (code >= 0) begin
      m.valid  = 1'b1;
      m.rd     = w[11:8];
      m.re     = 16'(1 << int'(w[11:8]));
      m.opcode = 5'(code);
      m.fe     = (code == 5 || code == 9);
      if (op == 0) begin
        m.rs = (code == 4) ? 4'h0 : w[3:0];
      end else begin
        m.ri = 1'b1;
        imm8 = int'(w[7:0]);
        if ((code == 5 || code == 9) && imm8 >= 128) imm8 = imm8 + 65280;
        m.imm = 16'(imm8);
      end
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {rs, rd, opcode, ri, fe, imm, re}, 64'd0);
  endtask

  task automatic chk_exec(input logic [15:0] w);
    ctl_t m;
    m = model(w);
    chk("exec_re", re, m.re);
    chk("exec_fe", fe, m.fe);
    chk("exec_halted", halted, 0);
    if (m.valid) begin
      chk("exec_rs", rs, m.rs);
      chk("exec_rd", rd, m.rd);
      chk("exec_opcode", opcode, m.opcode);
      chk("exec_ri", ri, m.ri);
      chk("exec_imm", imm, m.imm);
    end
  endtask

  // Runs one instruction from the edge entering FETCH up to sitting in EXEC.
  task automatic do_instr();
    logic [15:0] w;
    step();
    chk("fetch_addr", mem_addr, exp_pc);
    chk_quiet("fetch");
    w = mem[exp_pc];
    step();
    chk("decode_addr", mem_addr, exp_pc);
    chk_quiet("decode");
    step();
    chk("exec_addr", mem_addr, exp_pc);
    chk_exec(w);
    if (w[15:12] != 4'hF) exp_pc = (exp_pc + 1) % 256;
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst = 1'b0;
    #2;
    chk("rst_addr", mem_addr, 0);
    chk("rst_halted", halted, 0);
    chk_quiet("rst");
    step();
    rst = 1'b1;
    exp_pc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int base, n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h7000;
    for (int i = 0; i < 4; i++) mem2[i] = 16'h7000;
    run  = 1'b0;
    run2 = 1'b0;
    rst  = 1'b0;
    #1;
    chk("por_addr", mem_addr, 0);
    chk("por_addr_w2", mem_addr2, 0);
    chk("por_halted", halted, 0);
    chk_quiet("por");
    step();
    rst = 1'b1;

    // Narrow PC wraps; run dropped during DECODE still completes the instruction.
    run2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("w2_fetch_addr", mem_addr2, i % 4);
      chk("w2_ctl", {rs2, rd2, opcode2, ri2, fe2, imm2, halted2}, 0);
      step();
      step();
      chk("w2_exec_re", re2, 0);
    end
    step();
    chk("w2_addr1", mem_addr2, 1);
    step();
    run2 = 1'b0;
    step();
    chk("w2_exec_addr1", mem_addr2, 1);
    step();
    chk("w2_idle_addr", mem_addr2, 2);
    step();
    chk("w2_idle_hold", mem_addr2, 2);
    run2 = 1'b1;
    step();
    chk("w2_resume_addr", mem_addr2, 2);
    run2 = 1'b0;

    // ADDI R1,#1
    mem[0] = 16'h5101;
    run = 1'b1;
    do_instr();
    chk("addi_rd", rd, 1);
    chk("addi_re", re, 16'h0002);
    chk("addi_ri", ri, 1);
    chk("addi_imm", imm, 16'h0001);
    chk("addi_opcode", opcode, 5'b00101);
    chk("addi_fe", fe, 1);
    run = 1'b0;
    step();
    chk("addi_next_addr", mem_addr, 1);
    chk_quiet("addi_idle");

    // Register ADD R2,R1
    do_reset();
    mem[0] = 16'h0251;
    run = 1'b1;
    do_instr();
    chk("add_rd", rd, 2);
    chk("add_rs", rs, 1);
    chk("add_re", re, 16'h0004);
    chk("add_ri", ri, 0);
    chk("add_opcode", opcode, 5'b00101);
    chk("add_fe", fe, 1);

    // Immediate extension and NOT
    do_reset();
    mem[0] = 16'h53FE;
    mem[1] = 16'h1380;
    mem[2] = 16'h0A40;
    run = 1'b1;
    do_instr();
    chk("addi_neg_imm", imm, 16'hFFFE);
    chk("addi_neg_fe", fe, 1);
    do_instr();
    chk("andi_imm", imm, 16'h0080);
    chk("andi_fe", fe, 0);
    chk("andi_opcode", opcode, 5'b00001);
    do_instr();
    chk("not_rs", rs, 0);
    chk("not_rd", rd, 10);
    chk("not_opcode", opcode, 5'b00100);

    // ADD, NOP, HALT
    do_reset();
    mem[0] = 16'h0251;
    mem[1] = 16'h7000;
    mem[2] = 16'hF000;
    base = re_pulses;
    run = 1'b1;
    do_instr();
    do_instr();
    do_instr();
    step();
    chk("halt_halted", halted, 1);
    chk("halt_addr", mem_addr, 2);
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_hold_re", re, 0);
      chk("halt_hold_halted", halted, 1);
      chk("halt_hold_addr", mem_addr, 2);
    end
    chk("halt_re_pulses", re_pulses - base, 1);

    // Async reset in EXEC suppresses the write
    do_reset();
    mem[0] = 16'h5101;
    run = 1'b1;
    do_instr();
    chk("arst_pre_re", re, 16'h0002);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_re", re, 0);
    chk("arst_fe", fe, 0);
    chk("arst_addr", mem_addr, 0);
    base = r1_writes;
    run = 1'b0;
    step();
    chk("arst_no_write", r1_writes, base);
    rst = 1'b1;
    exp_pc = 0;

    // Random program with random run gaps
    do_reset();
    for (int k = 0; k < 48; k++) begin
      w = 16'($urandom());
      w[15:12] = 4'($urandom_range(0, 14));
      mem[k] = w;
    end
    run = 1'b1;
    for (int k = 0; k < 48; k++) begin
      do_instr();
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        step();
        chk("rand_idle_addr", mem_addr, exp_pc);
        chk_quiet("rand_idle");
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) begin
          step();
          chk("rand_idle_hold", mem_addr, exp_pc);
        end
        run = 1'b1;
      end
    end
    run = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
